// File: rtl/reg_bus_sequencer_pkg.sv
// Shared encodings for the register-bus sequencer: opcodes, FSM states, requester ids.
package reg_seq_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_INC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WRITE = 2'b10
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Command ports of both requesters plus the bus/strobe outputs consumed by the register bank.
interface reg_bus_sequencer_if #(
  parameter int NREG = 8,
  parameter int W    = 8
);
  localparam int IDX_W = $clog2(NREG);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [IDX_W-1:0] req0_src;
  logic [IDX_W-1:0] req0_dst;
  logic [W-1:0]     req0_imm;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [IDX_W-1:0] req1_src;
  logic [IDX_W-1:0] req1_dst;
  logic [W-1:0]     req1_imm;

  logic [IDX_W-1:0] bus_src_sel;
  logic             bus_imm_en;
  logic [W-1:0]     bus_imm;
  logic [NREG-1:0]  Wen;
  logic [NREG-1:0]  INC;
  logic [NREG-1:0]  RST;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             err;

  modport slave (
    input  req0_valid, req0_op, req0_src, req0_dst, req0_imm,
    input  req1_valid, req1_op, req1_src, req1_dst, req1_imm,
    output req0_ready, req1_ready,
    output bus_src_sel, bus_imm_en, bus_imm, Wen, INC, RST,
    output busy, done, done_id, err
  );

  modport master (
    output req0_valid, req0_op, req0_src, req0_dst, req0_imm,
    output req1_valid, req1_op, req1_src, req1_dst, req1_imm,
    input  req0_ready, req1_ready,
    input  bus_src_sel, bus_imm_en, bus_imm, Wen, INC, RST,
    input  busy, done, done_id, err
  );

endinterface

// File: rtl/reg_bus_sequencer_rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
// The pointer only moves when a grant is actually accepted.
module rr_arbiter2
  import reg_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == REQ1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept_i) last_d = gnt_o[1] ? REQ1 : REQ0;
  end

  // Pointer starts at REQ1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= REQ1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Arbitrates two command sources and sequences bus select plus Wen/INC/RST strobes for the register bank.
// Outputs are registered from the next state, so each state's outputs appear the cycle it is entered.
module reg_bus_sequencer
  import reg_seq_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input logic          Clk,
  input logic          RSTn,
  reg_bus_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NREG);

  state_e           state_q, state_d;
  op_e              c_op_q, c_op_d;
  logic [IDX_W-1:0] c_src_q, c_src_d;
  logic [IDX_W-1:0] c_dst_q, c_dst_d;
  logic [W-1:0]     c_imm_q, c_imm_d;
  logic             c_id_q, c_id_d;

  logic [1:0] req_vld, gnt;
  logic       accept;

  assign req_vld = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .clk_i    (Clk),
    .rst_ni   (RSTn),
    .req_i    (req_vld),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign bus.req0_ready = (state_q == S_IDLE) & gnt[0];
  assign bus.req1_ready = (state_q == S_IDLE) & gnt[1];
  assign accept         = (state_q == S_IDLE) & (|gnt);

  always_comb begin
    c_op_d  = c_op_q;
    c_src_d = c_src_q;
    c_dst_d = c_dst_q;
    c_imm_d = c_imm_q;
    c_id_d  = c_id_q;
    if (accept) begin
      if (gnt[1]) begin
        c_op_d  = op_e'(bus.req1_op);
        c_src_d = bus.req1_src;
        c_dst_d = bus.req1_dst;
        c_imm_d = bus.req1_imm;
        c_id_d  = REQ1;
      end else begin
        c_op_d  = op_e'(bus.req0_op);
        c_src_d = bus.req0_src;
        c_dst_d = bus.req0_dst;
        c_imm_d = bus.req0_imm;
        c_id_d  = REQ0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = (c_op_q == OP_MOV || c_op_q == OP_LDI) ? S_WRITE : S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, using the command that will be held in it.
  logic             bad_d;
  logic [NREG-1:0]  dst_oh_d;
  logic [IDX_W-1:0] src_sel_d, src_sel_q;
  logic             imm_en_d, imm_en_q;
  logic [W-1:0]     imm_out_d, imm_out_q;
  logic [NREG-1:0]  wen_d, wen_q, inc_d, inc_q, rst_d, rst_q;
  logic             busy_d, busy_q, done_d, done_q, done_id_d, done_id_q, err_d, err_q;

  always_comb begin
    bad_d     = (int'(c_dst_d) >= NREG) || (c_op_d == OP_MOV && int'(c_src_d) >= NREG);
    dst_oh_d  = bad_d ? '0 : (NREG'(1) << c_dst_d);
    src_sel_d = '0;
    imm_en_d  = 1'b0;
    imm_out_d = '0;
    wen_d     = '0;
    inc_d     = '0;
    rst_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    err_d     = 1'b0;
    case (state_d)
      S_ISSUE: begin
        busy_d = 1'b1;
        case (c_op_d)
          OP_MOV: src_sel_d = c_src_d;
          OP_LDI: begin
            imm_en_d  = 1'b1;
            imm_out_d = c_imm_d;
          end
          OP_INC, OP_CLR: begin
            if (c_op_d == OP_INC) inc_d = dst_oh_d;
            else                  rst_d = dst_oh_d;
            done_d    = 1'b1;
            done_id_d = c_id_d;
            err_d     = bad_d;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
        busy_d    = 1'b1;
        src_sel_d = (c_op_d == OP_MOV) ? c_src_d : '0;
        imm_en_d  = (c_op_d == OP_LDI);
        imm_out_d = (c_op_d == OP_LDI) ? c_imm_d : '0;
        wen_d     = dst_oh_d;
        done_d    = 1'b1;
        done_id_d = c_id_d;
        err_d     = bad_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      c_op_q    <= OP_MOV;
      c_src_q   <= '0;
      c_dst_q   <= '0;
      c_imm_q   <= '0;
      c_id_q    <= 1'b0;
      src_sel_q <= '0;
      imm_en_q  <= 1'b0;
      imm_out_q <= '0;
      wen_q     <= '0;
      inc_q     <= '0;
      rst_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_op_q    <= c_op_d;
      c_src_q   <= c_src_d;
      c_dst_q   <= c_dst_d;
      c_imm_q   <= c_imm_d;
      c_id_q    <= c_id_d;
      src_sel_q <= src_sel_d;
      imm_en_q  <= imm_en_d;
      imm_out_q <= imm_out_d;
      wen_q     <= wen_d;
      inc_q     <= inc_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  assign bus.bus_src_sel = src_sel_q;
  assign bus.bus_imm_en  = imm_en_q;
  assign bus.bus_imm     = imm_out_q;
  assign bus.Wen         = wen_q;
  assign bus.INC         = inc_q;
  assign bus.RST         = rst_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.err         = err_q;

endmodule
